// File: rtl/multi_ch_sma_engine_pkg.sv
// Shared FSM encodings and width/clamp helpers for the multi-channel SMA engine.
package multi_ch_sma_engine_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_DIVIDE = 2'd2;
    localparam logic [1:0] ST_OUTPUT = 2'd3;

    function automatic int win_width(input int max_win);
        return $clog2(max_win + 1);
    endfunction

    // Enough headroom that MAX_WIN full-scale samples never overflow the running sum.
    function automatic int sum_width(input int data_w, input int max_win);
        return data_w + $clog2(max_win);
    endfunction

    function automatic int clamp_win(input int req, input int max_win);
        if (req < 1) begin
            return 1;
        end
        if (req > max_win) begin
            return max_win;
        end
        return req;
    endfunction

endpackage

// File: rtl/multi_ch_sma_engine_seq_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first, floor result.
module multi_ch_sma_engine_seq_divider #(
    parameter int SUM_W = 20,
    parameter int WIN_W = 5,
    parameter int Q_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [WIN_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(SUM_W + 1);

    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [SUM_W-1:0] shreg_q, shreg_d;
    logic [WIN_W-1:0] rem_q, rem_d;
    logic [WIN_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W:0]   rem_shift;
    logic [WIN_W-1:0] rem_sub;
    logic             take;

    always_comb begin
        rem_shift = {rem_q, shreg_q[SUM_W-1]};
        rem_sub   = rem_shift[WIN_W-1:0] - dvs_q;
        take      = (rem_shift >= {1'b0, dvs_q});
        shreg_d   = shreg_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        if (start) begin
            shreg_d = dividend;
            rem_d   = '0;
            dvs_d   = divisor;
            cnt_d   = CNT_W'(SUM_W);
        end else if (cnt_q != '0) begin
            shreg_d = {shreg_q[SUM_W-2:0], take};
            rem_d   = take ? rem_sub : rem_shift[WIN_W-1:0];
            cnt_d   = cnt_q - CNT_W'(1);
        end
    end

    // Final quotient is presented combinationally during the last step cycle.
    assign done     = (cnt_q == CNT_W'(1));
    assign quotient = {shreg_q[Q_W-2:0], take};

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_ch_sma_engine.sv
// Multi-channel simple moving average: per-channel ring buffer and running sum, sequential divide.
// Handshake: a sample transfers on a rising clk when in_valid & in_ready; out_valid is a one-cycle pulse with no backpressure.
module multi_ch_sma_engine
    import multi_ch_sma_engine_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int MAX_WIN = 16,
    parameter int CH_W    = $clog2(NUM_CH),
    parameter int WIN_W   = win_width(MAX_WIN),
    parameter int SUM_W   = sum_width(DATA_W, MAX_WIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cfg_load,
    input  logic [WIN_W-1:0]  cfg_win,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_avg,
    output logic              out_warm,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(MAX_WIN);

    logic [1:0]        state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [SUM_W-1:0]  sum_q [NUM_CH];
    logic [SUM_W-1:0]  sum_d [NUM_CH];
    logic [WIN_W-1:0]  cnt_q [NUM_CH];
    logic [WIN_W-1:0]  cnt_d [NUM_CH];
    logic [PTR_W-1:0]  ptr_q [NUM_CH];
    logic [PTR_W-1:0]  ptr_d [NUM_CH];
    logic [DATA_W-1:0] ring_q [NUM_CH][MAX_WIN];
    logic              ring_we;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              warm_q, warm_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0] out_avg_q, out_avg_d;
    logic              out_warm_q, out_warm_d;
    logic              div_start, div_done;
    logic [SUM_W-1:0]  div_dividend;
    logic [WIN_W-1:0]  div_divisor;
    logic [DATA_W-1:0] div_quot;
    logic [SUM_W-1:0]  new_sum;
    logic [WIN_W-1:0]  new_cnt;
    logic [DATA_W-1:0] old_sample;

    assign in_ready  = (state_q == ST_IDLE) && !cfg_load;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_avg   = out_avg_q;
    assign out_warm  = out_warm_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        ch_d         = ch_q;
        data_d       = data_q;
        warm_d       = warm_q;
        out_valid_d  = 1'b0;
        out_ch_d     = out_ch_q;
        out_avg_d    = out_avg_q;
        out_warm_d   = out_warm_q;
        ring_we      = 1'b0;
        div_start    = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        old_sample   = ring_q[ch_q][ptr_q[ch_q]];
        new_sum      = sum_q[ch_q];
        new_cnt      = cnt_q[ch_q];
        case (state_q)
            ST_IDLE: begin
                if (cfg_load) begin
                    win_d = WIN_W'(clamp_win(int'(cfg_win), MAX_WIN));
                    for (int i = 0; i < NUM_CH; i++) begin
                        sum_d[i] = '0;
                        cnt_d[i] = '0;
                        ptr_d[i] = '0;
                    end
                end else if (in_valid && (int'(in_ch) < NUM_CH)) begin
                    ch_d    = in_ch;
                    data_d  = in_data;
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                // A full window retires the oldest sample; otherwise the window is still growing.
                if (cnt_q[ch_q] == win_q) begin
                    new_sum = sum_q[ch_q] + SUM_W'(data_q) - SUM_W'(old_sample);
                end else begin
                    new_sum = sum_q[ch_q] + SUM_W'(data_q);
                    new_cnt = cnt_q[ch_q] + WIN_W'(1);
                end
                sum_d[ch_q] = new_sum;
                cnt_d[ch_q] = new_cnt;
                ptr_d[ch_q] = (WIN_W'(ptr_q[ch_q]) == win_q - WIN_W'(1)) ? '0
                                                                         : ptr_q[ch_q] + PTR_W'(1);
                ring_we      = 1'b1;
                warm_d       = (new_cnt == win_q);
                div_start    = 1'b1;
                div_dividend = new_sum;
                div_divisor  = new_cnt;
                state_d      = ST_DIVIDE;
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    out_valid_d = 1'b1;
                    out_avg_d   = div_quot;
                    out_ch_d    = ch_q;
                    out_warm_d  = warm_q;
                    state_d     = ST_OUTPUT;
                end
            end
            ST_OUTPUT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    multi_ch_sma_engine_seq_divider #(
        .SUM_W(SUM_W),
        .WIN_W(WIN_W),
        .Q_W  (DATA_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .done    (div_done),
        .quotient(div_quot)
    );

    // Ring contents are never reset; counts decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (ring_we) begin
            ring_q[ch_q][ptr_q[ch_q]] <= data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= WIN_W'(MAX_WIN);
            for (int i = 0; i < NUM_CH; i++) begin
                sum_q[i] <= '0;
                cnt_q[i] <= '0;
                ptr_q[i] <= '0;
            end
            ch_q        <= '0;
            data_q      <= '0;
            warm_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_avg_q   <= '0;
            out_warm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            data_q      <= data_d;
            warm_q      <= warm_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_avg_q   <= out_avg_d;
            out_warm_q  <= out_warm_d;
        end
    end

endmodule

// File: tb/tb_multi_ch_sma_engine.sv
// Directed bench for multi_ch_sma_engine with a queue-based scoreboard and independent output monitor.
module tb_multi_ch_sma_engine;

    localparam int DATA_W  = 16;
    localparam int NUM_CH  = 4;
    localparam int MAX_WIN = 16;
    localparam int CH_W    = 2;
    localparam int WIN_W   = 5;
    localparam int SUM_W   = 20;
    localparam int EXP_W   = CH_W + DATA_W + 1;
    localparam int BOUND   = 200;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CH_W-1:0]   in_ch = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              cfg_load = 1'b0;
    logic [WIN_W-1:0]  cfg_win = '0;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_avg;
    logic              out_warm;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_out = 0;
    logic [EXP_W-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_ch_sma_engine #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .MAX_WIN(MAX_WIN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_data  (in_data),
        .cfg_load (cfg_load),
        .cfg_win  (cfg_win),
        .out_valid(out_valid),
        .out_ch   (out_ch),
        .out_avg  (out_avg),
        .out_warm (out_warm),
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (out_valid === 1'b1) begin
            n_out++;
            check("output_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_ch", 32'(out_ch), 32'(e[EXP_W-1 -: CH_W]));
                check("out_avg", 32'(out_avg), 32'(e[DATA_W:1]));
                check("out_warm", 32'(out_warm), 32'(e[0]));
            end
        end
    end

    // driver tasks
    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input int ch, input int data, input int avg, input int warm, input bit push);
        @(negedge clk);
        wait_ready();
        in_valid = 1'b1;
        in_ch    = CH_W'(ch);
        in_data  = DATA_W'(data);
        acc_cyc  = cyc;
        if (push) exp_q.push_back({CH_W'(ch), DATA_W'(avg), warm[0]});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic cfg(input int w);
        @(negedge clk);
        wait_ready();
        cfg_load = 1'b1;
        cfg_win  = WIN_W'(w);
        @(posedge clk);
        #1 cfg_load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || in_ready !== 1'b1) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int n0;
        int t5_avg[6];
        t5_avg = '{4, 6, 8, 10, 14, 18};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_out_avg", 32'(out_avg), 32'd0);
        check("rst_out_warm", 32'(out_warm), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_state", 32'(dbg_state), 32'd0);

        // window 4 warm-up then sliding
        cfg(4);
        send(0, 10, 10, 0, 1);
        send(0, 20, 15, 0, 1);
        send(0, 30, 20, 0, 1);
        send(0, 40, 25, 1, 1);
        send(0, 50, 35, 1, 1);

        // interleaved channels, window 2
        cfg(2);
        for (int i = 0; i < 3; i++) begin
            send(0, 100, 100, (i > 0) ? 1 : 0, 1);
            send(1, 8, 8, (i > 0) ? 1 : 0, 1);
        end

        // full-scale samples, full window
        cfg(16);
        for (int i = 0; i < 20; i++) begin
            send(3, 'hFFFF, 'hFFFF, (i >= 15) ? 1 : 0, 1);
        end

        // floor and exact latency / in_ready profile
        cfg(2);
        send(0, 1, 1, 0, 1);
        send(0, 2, 1, 1, 1);
        bad = 0;
        for (int k = 1; k <= SUM_W + 3; k++) begin
            @(negedge clk);
            if (in_ready !== 1'(k == SUM_W + 3)) bad++;
            if (out_valid !== 1'(k == SUM_W + 2)) bad++;
        end
        check("latency_handshake", 32'(bad), 32'd0);

        // reconfigure to window 1, ignored cfg during DIVIDE, cfg beats sample
        cfg(4);
        for (int i = 0; i < 6; i++) begin
            send(2, 4 * (i + 1), t5_avg[i], (i >= 3) ? 1 : 0, 1);
        end
        cfg(0);
        send(2, 7, 7, 1, 1);
        send(2, 9, 9, 1, 1);
        repeat (4) @(negedge clk);
        check("state_divide", 32'(dbg_state), 32'd2);
        cfg_load = 1'b1;
        cfg_win  = WIN_W'(5);
        @(posedge clk);
        #1 cfg_load = 1'b0;
        send(2, 3, 3, 1, 1);
        drain();
        cfg_load = 1'b1;
        cfg_win  = WIN_W'(1);
        in_valid = 1'b1;
        in_ch    = '0;
        in_data  = DATA_W'(50);
        #1 check("ready_under_cfg", 32'(in_ready), 32'd0);
        n0 = n_out;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("cfg_beats_sample", 32'(n_out), 32'(n0));
        send(3, 5, 5, 1, 1);

        // reset mid-DIVIDE aborts the transaction
        drain();
        send(1, 77, 0, 0, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n0 = n_out;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        check("no_out_after_rst", 32'(bad), 32'd0);
        check("rst_count_out", 32'(n_out), 32'(n0));
        check("mid_rst_out_ch", 32'(out_ch), 32'd0);
        check("mid_rst_out_avg", 32'(out_avg), 32'd0);
        check("mid_rst_out_warm", 32'(out_warm), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        send(0, 40, 40, 0, 1);
        send(0, 20, 30, 0, 1);

        drain();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
